// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift_reg_seq slice: opcodes and FSM state encoding.
package shift_reg_pkg;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_SHR  = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_INC  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_ASR  = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/shift_reg_seq_shift_step.sv
// shift_step: combinational single-bit step of the shift/rotate engine.
// Non-shift opcodes pass the data through unchanged with shout cleared.
module shift_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_i,
    input  logic             sin,
    output logic [WIDTH-1:0] data_o,
    output logic             shout_o
);

    // One step of the selected shift/rotate; bit leaving the register goes to shout_o.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch is inferred.
        data_o  = data_i;
        shout_o = 1'b0;
        case (op)
            OP_SHR: begin
                data_o  = {sin, data_i[WIDTH-1:1]};
                shout_o = data_i[0];
            end
            OP_SHL: begin
                data_o  = {data_i[WIDTH-2:0], sin};
                shout_o = data_i[WIDTH-1];
            end
            OP_ROR: begin
                data_o  = {data_i[0], data_i[WIDTH-1:1]};
                shout_o = data_i[0];
            end
            OP_ROL: begin
                data_o  = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
                shout_o = data_i[WIDTH-1];
            end
            OP_ASR: begin
                data_o  = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
                shout_o = data_i[0];
            end
            default: begin
                data_o  = data_i;
                shout_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_reg_seq.sv
// shift_reg_seq: sequential shift/rotate/increment register with a valid/ready command port.
// Default build: iterative engine, one bit per clock, FSM-driven.
// SHIFT_REG_BARREL_EN defined: every command completes in a single edge via a chain of steps.
module shift_reg_seq
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             sin,
    output logic [WIDTH-1:0] data_out,
    output logic             shout,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             shout_q, shout_d;
    logic             done_q, done_d;

    assign data_out = data_q;
    assign shout    = shout_q;
    assign done     = done_q;

`ifdef SHIFT_REG_BARREL_EN

    // Longest possible shift, so every amount resolves in one pass.
    localparam int N_STAGES = 2**AMT_W - 1;

    logic [WIDTH-1:0] chain_data  [0:N_STAGES];
    logic             chain_shout [0:N_STAGES];
    logic [WIDTH-1:0] stage_data  [0:N_STAGES-1];
    logic             stage_shout [0:N_STAGES-1];

    assign chain_data[0]  = data_q;
    assign chain_shout[0] = 1'b0;

    for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
        shift_step #(.WIDTH(WIDTH)) u_step (
            .op      (cmd_op),
            .data_i  (chain_data[i]),
            .sin     (sin),
            .data_o  (stage_data[i]),
            .shout_o (stage_shout[i])
        );
        // Stage i is applied only when the amount exceeds i, otherwise it passes through.
        assign chain_data[i+1]  = (AMT_W'(i) < cmd_amt) ? stage_data[i]  : chain_data[i];
        assign chain_shout[i+1] = (AMT_W'(i) < cmd_amt) ? stage_shout[i] : chain_shout[i];
    end

    assign busy      = 1'b0;
    assign cmd_ready = 1'b1;

    // Next state: any accepted command finishes on its acceptance edge.
    always_comb begin
        data_d  = data_q;
        shout_d = shout_q;
        done_d  = 1'b0;
        if (cmd_valid) begin
            done_d = 1'b1;
            case (cmd_op)
                OP_LOAD: begin
                    data_d  = cmd_data;
                    shout_d = 1'b0;
                end
                OP_INC:  {shout_d, data_d} = {1'b0, data_q} + (WIDTH+1)'(1);
                OP_CLR: begin
                    data_d  = '0;
                    shout_d = 1'b0;
                end
                default: begin
                    data_d  = chain_data[N_STAGES];
                    shout_d = chain_shout[N_STAGES];
                end
            endcase
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            data_q  <= '0;
            shout_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            shout_q <= shout_d;
            done_q  <= done_d;
        end
    end

`else

    state_e           state_q, state_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             sin_q, sin_d;

    logic [2:0]       step_op;
    logic             step_sin;
    logic [WIDTH-1:0] step_data;
    logic             step_shout;

    assign busy      = (state_q == SHIFT);
    assign cmd_ready = ~busy;

    // In IDLE the step works on the incoming command (step 1 happens at acceptance);
    // in SHIFT it works on the latched op/sin so input changes cannot disturb it.
    assign step_op  = (state_q == IDLE) ? cmd_op : op_q;
    assign step_sin = (state_q == IDLE) ? sin    : sin_q;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op      (step_op),
        .data_i  (data_q),
        .sin     (step_sin),
        .data_o  (step_data),
        .shout_o (step_shout)
    );

    // Next state: command decode in IDLE, one step per edge while in SHIFT.
    always_comb begin
        data_d  = data_q;
        shout_d = shout_q;
        done_d  = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sin_d   = sin_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    sin_d  = sin;
                    done_d = 1'b1;
                    case (cmd_op)
                        OP_LOAD: begin
                            data_d  = cmd_data;
                            shout_d = 1'b0;
                        end
                        OP_INC:  {shout_d, data_d} = {1'b0, data_q} + (WIDTH+1)'(1);
                        OP_CLR: begin
                            data_d  = '0;
                            shout_d = 1'b0;
                        end
                        default: begin
                            if (cmd_amt == '0) begin
                                shout_d = 1'b0;
                            end else begin
                                data_d  = step_data;
                                shout_d = step_shout;
                                if (cmd_amt != AMT_W'(1)) begin
                                    done_d  = 1'b0;
                                    state_d = SHIFT;
                                    cnt_d   = cmd_amt - AMT_W'(1);
                                end
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                data_d  = step_data;
                shout_d = step_shout;
                cnt_d   = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register update with synchronous reset; reset aborts any shift without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            shout_q <= 1'b0;
            done_q  <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_LOAD;
            sin_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            shout_q <= shout_d;
            done_q  <= done_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sin_q   <= sin_d;
        end
    end

`endif

endmodule

// File: tb/tb_shift_reg_seq.sv
// Self-checking bench for shift_reg_seq (WIDTH=8, AMT_W=4), either build mode.
module tb_shift_reg_seq;
    import shift_reg_pkg::*;

    localparam int W = 8;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_amt;
    logic [7:0] cmd_data;
    logic       sin;
    logic [7:0] data_out;
    logic       shout;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    shift_reg_seq #(.WIDTH(8), .AMT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .cmd_data  (cmd_data),
        .sin       (sin),
        .data_out  (data_out),
        .shout     (shout),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] data;
        logic       shout;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    // Value and shout after i single-bit steps, computed directly from the operation definition.
    function automatic logic [8:0] after_steps(input logic [2:0] op, input logic [7:0] d,
                                               input logic s, input int i);
        logic [7:0] v;
        logic [7:0] ones;
        logic       sh;
        int         r;
        ones = '1;
        r = i % W;
        v = d;
        sh = 1'b0;
        case (op)
            OP_SHR: begin
                v  = (i >= W) ? {W{s}} : ((d >> i) | (s ? ~(ones >> i) : 8'h00));
                sh = (i <= W) ? d[i-1] : s;
            end
            OP_SHL: begin
                v  = (i >= W) ? {W{s}} : ((d << i) | (s ? ~(ones << i) : 8'h00));
                sh = (i <= W) ? d[W-i] : s;
            end
            OP_ROR: begin
                v  = (d >> r) | (d << (W - r));
                sh = d[(i-1) % W];
            end
            OP_ROL: begin
                v  = (d << r) | (d >> (W - r));
                sh = d[W-1-((i-1) % W)];
            end
            OP_ASR: begin
                v  = (i >= W) ? {W{d[W-1]}} : 8'($signed(d) >>> i);
                sh = (i <= W) ? d[i-1] : d[W-1];
            end
            default: begin
                v  = d;
                sh = 1'b0;
            end
        endcase
        return {sh, v};
    endfunction

    task automatic model_accept(input logic [2:0] op, input int amt, input logic [7:0] din,
                                input logic s, input logic [7:0] base);
        logic [8:0] r;
        case (op)
            OP_LOAD: exp_q.push_back('{din, 1'b0, 1'b0, 1'b1});
            OP_INC: begin
                r = {1'b0, base} + 9'd1;
                exp_q.push_back('{r[7:0], r[8], 1'b0, 1'b1});
            end
            OP_CLR: exp_q.push_back('{8'h00, 1'b0, 1'b0, 1'b1});
            default: begin
                if (amt == 0) begin
                    exp_q.push_back('{base, 1'b0, 1'b0, 1'b1});
                end else begin
`ifdef SHIFT_REG_BARREL_EN
                    r = after_steps(op, base, s, amt);
                    exp_q.push_back('{r[7:0], r[8], 1'b0, 1'b1});
`else
                    for (int i = 1; i <= amt; i++) begin
                        r = after_steps(op, base, s, i);
                        exp_q.push_back('{r[7:0], r[8], (i < amt), (i == amt)});
                    end
`endif
                end
            end
        endcase
    endtask

    // Model advance: acceptance judged from the model's own busy expectation.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            cur = '{8'h00, 1'b0, 1'b0, 1'b0};
        end else begin
            if (cmd_valid && !cur.busy)
                model_accept(cmd_op, int'(cmd_amt), cmd_data, sin, cur.data);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
            end else begin
                cur.busy = 1'b0;
                cur.done = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en)
            check("cycle", {20'h0, data_out, shout, busy, done, cmd_ready},
                  {20'h0, cur.data, cur.shout, cur.busy, cur.done, !cur.busy});
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a command for one edge; returns in the cycle after that edge.
    task automatic send(input logic [2:0] op, input int amt, input logic [7:0] d, input logic s);
        cmd_op    = op;
        cmd_amt   = amt[3:0];
        cmd_data  = d;
        sin       = s;
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    // Issue a command and wait (bounded) for done; checks completion latency.
    task automatic run(input logic [2:0] op, input int amt, input logic [7:0] d, input logic s,
                       input int exp_lat, input string name);
        int lat;
        send(op, amt, d, s);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            tick(1);
            lat++;
        end
`ifdef SHIFT_REG_BARREL_EN
        exp_lat = 1;
`endif
        check({name, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_LOAD;
        cmd_amt   = '0;
        cmd_data  = '0;
        sin       = 1'b0;
        tick(2);
        check("reset_state", {data_out, shout, busy, done, cmd_ready}, {8'h00, 4'b0001});
        reset  = 1'b0;
        chk_en = 1'b1;

        // 1: LOAD
        send(OP_LOAD, 0, 8'hA5, 1'b0);
        check("t1_load", {data_out, shout, busy, done}, {8'hA5, 3'b001});

        // 2: SHR by 3 with sin=1, commands during busy ignored, op/sin latched
        send(OP_LOAD, 0, 8'h81, 1'b0);
`ifndef SHIFT_REG_BARREL_EN
        send(OP_SHR, 3, 8'h00, 1'b1);
        check("t2_e1", {data_out, shout, busy, done}, {8'hC0, 3'b110});
        cmd_op    = OP_LOAD;
        cmd_data  = 8'h55;
        sin       = 1'b0;
        cmd_valid = 1'b1;
        tick(1);
        check("t2_e2", {data_out, shout, busy, done}, {8'hE0, 3'b010});
        tick(1);
        cmd_valid = 1'b0;
        check("t2_e3", {data_out, shout, busy, done}, {8'hF0, 3'b001});
        tick(1);
        check("t2_ignored", {data_out, done}, {8'hF0, 1'b0});
`else
        run(OP_SHR, 3, 8'h00, 1'b1, 3, "t2_shr");
        check("t2_shr", {data_out, shout}, {8'hF0, 1'b0});
`endif

        // 3: ROL by 9 wraps; ASR keeps the sign
        send(OP_LOAD, 0, 8'h81, 1'b0);
        run(OP_ROL, 9, 8'h00, 1'b0, 9, "t3_rol");
        check("t3_rol", {data_out, shout}, {8'h03, 1'b1});
        send(OP_LOAD, 0, 8'h90, 1'b0);
        run(OP_ASR, 2, 8'h00, 1'b0, 2, "t3_asr");
        check("t3_asr", {data_out, shout}, {8'hE4, 1'b0});

        // 4: INC wrap and carry, then SHL by 0
        send(OP_LOAD, 0, 8'hFF, 1'b0);
        run(OP_INC, 0, 8'h00, 1'b0, 1, "t4_inc1");
        check("t4_inc1", {data_out, shout}, {8'h00, 1'b1});
        run(OP_INC, 0, 8'h00, 1'b0, 1, "t4_inc2");
        check("t4_inc2", {data_out, shout}, {8'h01, 1'b0});
        run(OP_SHL, 0, 8'h00, 1'b1, 1, "t4_shl0");
        check("t4_shl0", {data_out, shout, busy}, {8'h01, 2'b00});

        // Boundary amounts and remaining ops, issued back-to-back
        send(OP_LOAD, 0, 8'h81, 1'b0);
        run(OP_ROR, 3, 8'h00, 1'b0, 3, "ror3");
        check("ror3", {data_out, shout}, {8'h30, 1'b0});
        send(OP_LOAD, 0, 8'h12, 1'b0);
        run(OP_SHL, 10, 8'h00, 1'b1, 10, "shl10");
        check("shl10", {data_out, shout}, {8'hFF, 1'b1});
        send(OP_LOAD, 0, 8'h80, 1'b0);
        run(OP_SHR, 8, 8'h00, 1'b0, 8, "shr8");
        check("shr8", {data_out, shout}, {8'h00, 1'b1});
        send(OP_LOAD, 0, 8'h80, 1'b0);
        run(OP_ASR, 15, 8'h00, 1'b0, 15, "asr15");
        check("asr15", {data_out, shout}, {8'hFF, 1'b1});
        run(OP_CLR, 0, 8'h00, 1'b0, 1, "clr");
        check("clr", {data_out, shout}, {8'h00, 1'b0});
        send(OP_LOAD, 0, 8'h02, 1'b0);
        run(OP_SHR, 1, 8'h00, 1'b1, 1, "shr1");
        check("shr1", {data_out, shout, busy}, {8'h81, 2'b00});

        // 5: reset in the middle of a long shift
        send(OP_LOAD, 0, 8'h01, 1'b0);
        send(OP_SHL, 7, 8'h00, 1'b0);
        tick(1);
        reset = 1'b1;
        tick(1);
        check("t5_reset", {data_out, shout, busy, done, cmd_ready}, {8'h00, 4'b0001});
        reset = 1'b0;
        tick(8);
        check("t5_quiet", {data_out, busy, done}, {8'h00, 2'b00});

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
